// File: rtl/paint_brush_ctrl.sv
// Paint brush controller: stamps a (2r+1)^2 square brush into a 640x480 paint RAM
// and performs full-frame clears, one RAM write per cycle.
module paint_brush_ctrl #(
  parameter int N           = 19,
  parameter int CLEAR_WORDS = 307200
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pen_valid,
  output logic         pen_ready,
  input  logic [9:0]   pen_x,
  input  logic [8:0]   pen_y,
  input  logic [2:0]   pen_color,
  input  logic [1:0]   brush_r,
  input  logic         clear_req,
  output logic [N-1:0] wr_addr,
  output logic         wren,
  output logic [2:0]   wr_data,
  output logic         busy,
  output logic         clear_done
);

  typedef enum logic [1:0] {IDLE, STAMP, CLEAR} state_t;

  localparam logic [18:0] CLEAR_LAST = 19'(CLEAR_WORDS - 1);

  state_t state, state_next;
  logic   clear_pend;
  logic   accept, enter_clear, stamp_last, oob;

  logic [9:0]  lat_x;
  logic [8:0]  lat_y;
  logic [2:0]  lat_color;
  logic [1:0]  lat_r;
  logic [18:0] clr_cnt;

  // dx/dy hold the offset of the pixel currently on the write outputs
  logic signed [2:0]  dx, dy, ndx, ndy, r_s;
  logic [9:0]         bx;
  logic [8:0]         by;
  logic signed [10:0] sx;
  logic signed [9:0]  sy;
  logic [N-1:0]       pix_addr;

  assign pen_ready   = !reset && (state == IDLE) && !clear_pend && !clear_req;
  assign busy        = !reset && ((state != IDLE) || clear_pend);
  assign accept      = pen_valid && pen_ready;
  assign r_s         = $signed({1'b0, lat_r});
  assign stamp_last  = (dx == r_s) && (dy == r_s);
  assign enter_clear = (state_next == CLEAR) && (state != CLEAR);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (clear_req || clear_pend) state_next = CLEAR;
               else if (accept)            state_next = STAMP;
      STAMP:   if (stamp_last) state_next = (clear_pend || clear_req) ? CLEAR : IDLE;
      CLEAR:   if (clr_cnt == CLEAR_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // In IDLE the next pixel is the first one of a stamp taken straight from the pen inputs
  always_comb begin
    bx  = lat_x;
    by  = lat_y;
    ndx = dx;
    ndy = dy;
    if (state == IDLE) begin
      bx  = pen_x;
      by  = pen_y;
      ndx = -$signed({1'b0, brush_r});
      ndy = -$signed({1'b0, brush_r});
    end else if (dx == r_s) begin
      ndx = -r_s;
      ndy = dy + 3'sd1;
    end else begin
      ndx = dx + 3'sd1;
    end
    sx       = $signed({1'b0, bx}) + 11'(ndx);
    sy       = $signed({1'b0, by}) + 10'(ndy);
    oob      = (sx < 11'sd0) || (sx > 11'sd639) || (sy < 10'sd0) || (sy > 10'sd479);
    pix_addr = (N'(sy[8:0]) << 9) + (N'(sy[8:0]) << 7) + N'(sx[9:0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clear_pend <= 1'b0;
      wren       <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      clear_done <= 1'b0;
      clr_cnt    <= '0;
      lat_x      <= '0;
      lat_y      <= '0;
      lat_color  <= '0;
      lat_r      <= '0;
      dx         <= '0;
      dy         <= '0;
    end else begin
      wren       <= 1'b0;
      clear_done <= 1'b0;
      if (enter_clear)                         clear_pend <= 1'b0;
      else if (clear_req && (state != CLEAR)) clear_pend <= 1'b1;

      if (enter_clear) begin
        clr_cnt <= '0;
        wr_addr <= '0;
        wr_data <= '0;
        wren    <= 1'b1;
      end else if (state == CLEAR) begin
        if (clr_cnt == CLEAR_LAST) begin
          clear_done <= 1'b1;
        end else begin
          clr_cnt <= clr_cnt + 19'd1;
          wr_addr <= N'(clr_cnt + 19'd1);
          wren    <= 1'b1;
        end
      end else if (accept || ((state == STAMP) && !stamp_last)) begin
        if (accept) begin
          lat_x     <= pen_x;
          lat_y     <= pen_y;
          lat_color <= pen_color;
          lat_r     <= brush_r;
        end
        dx <= ndx;
        dy <= ndy;
        // Off-frame pixels still take their cycle but leave the RAM untouched
        if (!oob) begin
          wren    <= 1'b1;
          wr_addr <= pix_addr;
          wr_data <= accept ? pen_color : lat_color;
        end
      end
    end
  end

endmodule

// File: tb/tb_paint_brush_ctrl.sv
// Self-checking bench for paint_brush_ctrl: stamp vector table, clear/reset sequences,
// and a cycle-accurate write scoreboard.
module tb_paint_brush_ctrl;

  localparam int N  = 19;
  localparam int CW = 1500;

  logic         clk = 1'b0;
  logic         reset;
  logic         pen_valid;
  logic         pen_ready;
  logic [9:0]   pen_x;
  logic [8:0]   pen_y;
  logic [2:0]   pen_color;
  logic [1:0]   brush_r;
  logic         clear_req;
  logic [N-1:0] wr_addr;
  logic         wren;
  logic [2:0]   wr_data;
  logic         busy;
  logic         clear_done;

  paint_brush_ctrl #(.N(N), .CLEAR_WORDS(CW)) dut (
    .clk(clk), .reset(reset), .pen_valid(pen_valid), .pen_ready(pen_ready),
    .pen_x(pen_x), .pen_y(pen_y), .pen_color(pen_color), .brush_r(brush_r),
    .clear_req(clear_req), .wr_addr(wr_addr), .wren(wren), .wr_data(wr_data),
    .busy(busy), .clear_done(clear_done)
  );

  always #5 clk = ~clk;

  typedef struct {int addr; int data; int cyc;} sb_t;
  typedef struct {int x; int y; int color; int r; int exp_writes; int exp_len;} vec_t;

  sb_t  sb[$];
  sb_t  e;
  vec_t vecs[6];
  int   tests = 0, fails = 0;
  int   cyc = 0, wr_cnt = 0, done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Every write is matched against the model in order; stamp writes also by cycle
  always @(negedge clk) begin
    if (!reset) begin
      if (clear_done) done_cnt++;
      if (wren) begin
        wr_cnt++;
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("[TB] FAIL sb_write unexpected addr=%0d data=%0d cyc=%0d, expected none",
                   wr_addr, wr_data, cyc);
        end else begin
          e = sb.pop_front();
          if (int'(wr_addr) != e.addr || int'(wr_data) != e.data || (e.cyc >= 0 && cyc != e.cyc)) begin
            fails++;
            $display("[TB] FAIL sb_write got addr=%0d data=%0d cyc=%0d, expected addr=%0d data=%0d cyc=%0d",
                     wr_addr, wr_data, cyc, e.addr, e.data, e.cyc);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic pushStamp(input int x, input int y, input int c, input int r, input int a);
    int k = 0;
    for (int oy = -r; oy <= r; oy++) begin
      for (int ox = -r; ox <= r; ox++) begin
        if (x + ox >= 0 && x + ox < 640 && y + oy >= 0 && y + oy < 480)
          sb.push_back('{(y + oy) * 640 + (x + ox), c, a + k + 1});
        k++;
      end
    end
  endtask

  task automatic pushClear();
    for (int i = 0; i < CW; i++) sb.push_back('{i, 0, -1});
  endtask

  task automatic drivePen(input int x, input int y, input int c, input int r);
    pen_x     = 10'(x);
    pen_y     = 9'(y);
    pen_color = 3'(c);
    brush_r   = 2'(r);
    pen_valid = 1'b1;
  endtask

  task automatic scramblePen();
    pen_valid = 1'b0;
    pen_x     = 10'($urandom);
    pen_y     = 9'($urandom);
    pen_color = 3'($urandom);
    brush_r   = 2'($urandom);
  endtask

  task automatic waitReady(input string name, input int exp_len);
    int n = 1;
    while (!pen_ready && n < 400) begin
      tick();
      n++;
    end
    checkOutput(name, n, exp_len);
  endtask

  task automatic applyStimulus(input vec_t v);
    int w0;
    checkOutput("pen_ready_pre", int'(pen_ready), 1);
    w0 = wr_cnt;
    pushStamp(v.x, v.y, v.color, v.r, cyc);
    drivePen(v.x, v.y, v.color, v.r);
    tick();
    scramblePen();
    waitReady("stamp_len", v.exp_len);
    checkOutput("stamp_writes", wr_cnt - w0, v.exp_writes);
    checkOutput("sb_drained", sb.size(), 0);
  endtask

  initial begin
    int n, early, d0, w0;
    vecs[0] = '{100, 50, 3, 1, 9, 10};
    vecs[1] = '{0, 0, 5, 2, 9, 26};
    vecs[2] = '{639, 479, 7, 3, 16, 50};
    vecs[3] = '{320, 240, 0, 0, 1, 2};
    vecs[4] = '{639, 0, 2, 1, 4, 10};
    vecs[5] = '{5, 478, 6, 3, 35, 50};

    reset = 1'b1;
    clear_req = 1'b0;
    scramblePen();
    tick();
    tick();
    checkOutput("rst_wren", int'(wren), 0);
    checkOutput("rst_wr_addr", int'(wr_addr), 0);
    checkOutput("rst_wr_data", int'(wr_data), 0);
    checkOutput("rst_clear_done", int'(clear_done), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_pen_ready", int'(pen_ready), 0);
    reset = 1'b0;
    #1;
    checkOutput("post_rst_ready", int'(pen_ready), 1);
    checkOutput("post_rst_busy", int'(busy), 0);
    tick();

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
      if (i == 0) begin
        checkOutput("hold_wr_addr", int'(wr_addr), 32741);
        checkOutput("hold_wr_data", int'(wr_data), 3);
        checkOutput("idle_wren", int'(wren), 0);
      end
    end

    // Clear pulsed mid-stamp: the stamp must finish before the clear sweep
    d0 = done_cnt;
    w0 = wr_cnt;
    pushStamp(100, 50, 4, 2, cyc);
    drivePen(100, 50, 4, 2);
    tick();
    scramblePen();
    repeat (4) tick();
    clear_req = 1'b1;
    pushClear();
    tick();
    clear_req = 1'b0;
    checkOutput("busy_mid_stamp", int'(busy), 1);
    n = 0;
    early = 0;
    while (!clear_done && n < CW + 200) begin
      if (pen_ready) early++;
      tick();
      n++;
    end
    checkOutput("clr_done_seen", int'(clear_done), 1);
    checkOutput("ready_before_done", early, 0);
    checkOutput("clr_writes", wr_cnt - w0, 25 + CW);
    checkOutput("clr_drained", sb.size(), 0);
    repeat (3) tick();
    checkOutput("clr_done_once", done_cnt - d0, 1);
    checkOutput("busy_after_clr", int'(busy), 0);
    checkOutput("wren_after_clr", int'(wren), 0);

    // Clear and pen together in IDLE: clear wins, pen waits for clear_done
    d0 = done_cnt;
    drivePen(200, 100, 6, 1);
    clear_req = 1'b1;
    #1;
    checkOutput("ready_clr_pen", int'(pen_ready), 0);
    pushClear();
    tick();
    clear_req = 1'b0;
    n = 0;
    while (!pen_ready && n < CW + 200) begin
      tick();
      n++;
    end
    checkOutput("pen_after_done", (done_cnt - d0) + int'(clear_done), 1);
    checkOutput("clr2_drained", sb.size(), 0);
    pushStamp(200, 100, 6, 1, cyc);
    tick();
    scramblePen();
    waitReady("pen_after_clr_len", 10);
    checkOutput("sb2_drained", sb.size(), 0);

    // Reset in the middle of a clear aborts it silently
    d0 = done_cnt;
    clear_req = 1'b1;
    pushClear();
    tick();
    clear_req = 1'b0;
    n = 0;
    while (!(wren && int'(wr_addr) == 1000) && n < CW + 50) begin
      tick();
      n++;
    end
    checkOutput("clr_at_1000", int'(wr_addr), 1000);
    reset = 1'b1;
    #1;
    checkOutput("rst2_ready", int'(pen_ready), 0);
    checkOutput("rst2_busy", int'(busy), 0);
    tick();
    checkOutput("rst2_wren", int'(wren), 0);
    checkOutput("rst2_wr_addr", int'(wr_addr), 0);
    checkOutput("rst2_clear_done", int'(clear_done), 0);
    sb.delete();
    reset = 1'b0;
    #1;
    checkOutput("rst2_release_ready", int'(pen_ready), 1);
    tick();
    repeat (3) tick();
    checkOutput("rst2_no_done", done_cnt - d0, 0);
    applyStimulus(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    fails++;
    $display("[TB] FAIL watchdog timeout");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
